// File: rtl/instr_queue_pkg.sv
// Shared frontend constants and the fetch-beat entry layout for instr_queue.
package instr_queue_pkg;

   localparam int unsigned FE_DW    = 64;
   localparam int unsigned SLOT_W   = 32;
   localparam int unsigned PC_W     = 64;
   localparam logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000;

   // One stored fetch beat: two instruction slots, 8-byte aligned pc, first valid slot
   typedef struct packed {
      logic [FE_DW-1:0] data;
      logic [PC_W-4:0]  pc_hi;
      logic             start;
   } beat_t;

endpackage

// File: rtl/instr_queue.sv
// Fetch-beat queue feeding decode one 32-bit instruction per handshake.
// Optional same-cycle bypass of a push into an empty queue: INSTR_QUEUE_BYPASS_EN.
module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int unsigned DW    = FE_DW,
   parameter int unsigned DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          flush,
   input  logic          push_valid,
   input  logic [DW-1:0] push_data,
   input  logic [63:0]   push_pc,
   output logic          instrFifo_full,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic [63:0]   out_pc,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

`ifdef INSTR_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   beat_t           mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr, rd_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic            slot, slot_nxt;
   logic            full_q, empty_q;

   beat_t           push_beat, head;
   logic            push_acc, byp, head_slot, fire, pop_free, consumed_all, store;
   logic            unused_pc_lo;

   assign unused_pc_lo   = ^push_pc[1:0];
   assign instrFifo_full = full_q;
   assign empty          = empty_q;

   // Head selection, handshake decode and the store decision
   always_comb begin
      push_beat.data  = push_data;
      push_beat.pc_hi = push_pc[63:3];
      push_beat.start = push_pc[2];
      push_acc     = push_valid & ~full_q & ~flush;
      byp          = BYP & empty_q & push_valid;
      head         = byp ? push_beat : mem[rd_ptr];
      head_slot    = byp ? push_pc[2] : slot;
      out_valid    = (~empty_q | byp) & ~flush;
      out_instr    = head_slot ? head.data[63:32] : head.data[31:0];
      out_pc       = {head.pc_hi, head_slot, 2'b00};
      fire         = out_valid & out_ready;
      pop_free     = fire & ~empty_q & slot;
      consumed_all = fire & byp & push_pc[2];
      store        = push_acc & ~consumed_all;
      rd_nxt       = rd_ptr + AW'(1);
   end

   // Occupancy and slot pointer for the next head
   always_comb begin
      count_nxt = count;
      slot_nxt  = slot;
      if (store & ~pop_free)
         count_nxt = count + CW'(1);
      else if (pop_free & ~store)
         count_nxt = count - CW'(1);

      if (pop_free)
         slot_nxt = (count > CW'(1)) ? mem[rd_nxt].start : push_pc[2];
      else if (fire & ~empty_q)
         slot_nxt = 1'b1;
      else if (empty_q & store)
         slot_nxt = push_pc[2] | fire;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         slot    <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         slot    <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (store)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_free)
            rd_ptr <= rd_nxt;
         count   <= count_nxt;
         slot    <= slot_nxt;
         full_q  <= (count_nxt == CW'(DEPTH));
         empty_q <= (count_nxt == '0);
      end
   end

   // Entry storage carries no reset; occupancy alone marks validity
   always_ff @(posedge CLK) begin
      if (store)
         mem[wr_ptr] <= push_beat;
   end

endmodule
